// File: rtl/mfe_led7seg_pkg.sv
// mfe_led7seg_pkg: segment code table, decode helpers and chain width for the 74HC595 receiver.
package mfe_led7seg_pkg;
   localparam int WORD_W = 16;
   localparam logic [7:0] NUM_0 = 8'hC0;
   localparam logic [7:0] NUM_1 = 8'hF9;
   localparam logic [7:0] NUM_2 = 8'hA4;
   localparam logic [7:0] NUM_3 = 8'hB0;
   localparam logic [7:0] NUM_4 = 8'h99;
   localparam logic [7:0] NUM_5 = 8'h92;
   localparam logic [7:0] NUM_6 = 8'h82;
   localparam logic [7:0] NUM_7 = 8'hF8;
   localparam logic [7:0] NUM_8 = 8'h80;
   localparam logic [7:0] NUM_9 = 8'h90;
   localparam logic [7:0] NUM_LINE = 8'hBF;

   // 0xF marks a code that is not a decimal digit
   function automatic logic [3:0] seg2num(input logic [7:0] seg);
      return seg == NUM_0 ? 4'd0 : seg == NUM_1 ? 4'd1 : seg == NUM_2 ? 4'd2 :
             seg == NUM_3 ? 4'd3 : seg == NUM_4 ? 4'd4 : seg == NUM_5 ? 4'd5 :
             seg == NUM_6 ? 4'd6 : seg == NUM_7 ? 4'd7 : seg == NUM_8 ? 4'd8 :
             seg == NUM_9 ? 4'd9 : 4'hF;
   endfunction

   function automatic logic [4:0] onehot2idx(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++)
         if (v[i]) idx = 5'(i);
      return idx;
   endfunction
endpackage

// File: rtl/mfe_led7seg_74hc595_receiver_sync.sv
// mfe_sync_edge: multi-stage synchronizer with a history flop for rising-edge detection.
module mfe_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise
);
   logic [SYNC_STAGES-1:0] chain;
   logic hist;

   always_ff @(posedge clk) begin
      if (!rst) begin
         chain <= '0;
         hist <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         hist <= chain[SYNC_STAGES-1];
      end
   end

   assign sync = chain[SYNC_STAGES-1];
   assign rise = sync & ~hist;
endmodule

// File: rtl/mfe_led7seg_74hc595_receiver.sv
// mfe_led7seg_74hc595_receiver: mirrors a 74HC595 7-seg chain and keeps a decoded frame buffer.
module mfe_led7seg_74hc595_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int NDIG = 8,
   parameter int WORD_W = 8 + NDIG
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic rclk,
   input  logic dio,
   output logic [WORD_W-1:0] dat,
   output logic vld,
   output logic err,
   output logic [8*NDIG-1:0] frame,
   output logic frame_upd,
   output logic [4*NDIG-1:0] num,
   output logic [NDIG-1:0] num_ok
);
   import mfe_led7seg_pkg::*;

   localparam int IW = $clog2(NDIG);

   logic rise_s, rise_r, dio_s, sclk_s, rclk_s, dio_r, unused;
   logic [WORD_W-1:0] sh;
   logic [4:0] bitcnt;
   logic [NDIG-1:0][7:0] fr;
   logic [NDIG-1:0][3:0] nm;
   logic [NDIG-1:0] sel;
   logic [7:0] seg;
   logic [3:0] code;
   logic [IW-1:0] idx;
   logic wr;

   mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .din(sclk), .sync(sclk_s), .rise(rise_s));
   mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rclk (.clk(clk), .rst(rst), .din(rclk), .sync(rclk_s), .rise(rise_r));
   mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dio (.clk(clk), .rst(rst), .din(dio), .sync(dio_s), .rise(dio_r));

   assign unused = ^{sclk_s, rclk_s, dio_r};
   assign sel = dat[NDIG-1:0];
   assign seg = dat[WORD_W-1:NDIG];
   assign code = seg2num(seg);
   assign idx = IW'(onehot2idx(32'(sel)));
   // frame write is the pending stage behind vld, so dat already holds the word
   assign wr = vld && $onehot(sel);
   assign frame = fr;
   assign num = nm;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sh <= '0;
         dat <= '0;
         bitcnt <= '0;
         vld <= 1'b0;
         err <= 1'b0;
         frame_upd <= 1'b0;
         fr <= {NDIG{8'hFF}};
         nm <= {NDIG{4'hF}};
         num_ok <= '0;
      end else begin
         vld <= rise_r;
         err <= rise_r && bitcnt != 5'(WORD_W);
         if (rise_r) dat <= sh;
         if (rise_s) sh <= {sh[WORD_W-2:0], dio_s};
         // a coincident shift is the first bit of the next word
         bitcnt <= rise_r ? {4'd0, rise_s} : (rise_s && bitcnt != 5'd31) ? bitcnt + 5'd1 : bitcnt;
         frame_upd <= wr;
         if (wr) begin
            fr[idx] <= seg;
            nm[idx] <= code;
            num_ok[idx] <= code != 4'hF;
         end
      end
   end
endmodule

// File: tb/tb_mfe_led7seg_74hc595_receiver.sv
// tb_mfe_led7seg_74hc595_receiver: randomized pin-level stimulus checked against a word/frame model.
module tb_mfe_led7seg_74hc595_receiver;
   logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, rclk = 1'b0, dio = 1'b0;
   logic [15:0] dat;
   logic vld, err, frame_upd;
   logic [63:0] frame;
   logic [31:0] num;
   logic [7:0] num_ok;

   always #5 clk = ~clk;

   mfe_led7seg_74hc595_receiver dut (
      .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
      .dat(dat), .vld(vld), .err(err), .frame(frame), .frame_upd(frame_upd),
      .num(num), .num_ok(num_ok)
   );

   typedef struct packed {
      logic [15:0] d;
      logic e;
   } lat_t;

   lat_t exp_q[$];
   logic [15:0] msh = '0;
   int mcnt = 0;
   logic [7:0] mfr[8];
   logic [7:0] tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int n_chk = 0, n_fail = 0, n_upd = 0;
   logic [15:0] last_dat = '0;
   logic last_err = 1'b0;
   logic pend_v = 1'b0;
   logic [15:0] pend_w = '0;

   function automatic logic [3:0] dec(input logic [7:0] s);
      for (int i = 0; i < 10; i++)
         if (tbl[i] == s) return 4'(i);
      return 4'hF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // model: a latched word with exactly one select bit rewrites that digit one cycle after vld
   always @(negedge clk) begin : cmp
      logic [63:0] ef;
      logic [31:0] en;
      logic [7:0] eo;
      logic hot;
      lat_t e;
      if (!rst) begin
         for (int i = 0; i < 8; i++) mfr[i] = 8'hFF;
         pend_v = 1'b0;
      end else begin
         hot = pend_v && $countones(pend_w[7:0]) == 1;
         if (hot)
            for (int i = 0; i < 8; i++)
               if (pend_w[i]) mfr[i] = pend_w[15:8];
         chk("frame_upd", 64'(frame_upd), 64'(hot));
         if (frame_upd) n_upd++;
         pend_v = 1'b0;
         for (int i = 0; i < 8; i++) begin
            ef[i*8 +: 8] = mfr[i];
            en[i*4 +: 4] = dec(mfr[i]);
            eo[i] = dec(mfr[i]) != 4'hF;
         end
         chk("frame", frame, ef);
         chk("num", 64'(num), 64'(en));
         chk("num_ok", 64'(num_ok), 64'(eo));
         if (vld) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_vld: got dat %0h, expected no latch", dat);
            end else begin
               e = exp_q.pop_front();
               chk("dat", 64'(dat), 64'(e.d));
               chk("err", 64'(err), 64'(e.e));
               pend_v = 1'b1;
               pend_w = e.d;
            end
            last_dat = dat;
            last_err = err;
         end else
            chk("err_idle", 64'(err), 64'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk);
      #2 dio = b;
      idle(2);
      #2 sclk = 1'b1;
      msh = {msh[14:0], b};
      mcnt = mcnt == 31 ? 31 : mcnt + 1;
      idle(3);
      #2 sclk = 1'b0;
      idle(2);
   endtask

   task automatic send_word(input logic [15:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_rclk();
      @(posedge clk);
      #2 rclk = 1'b1;
      exp_q.push_back('{d: msh, e: mcnt != 16});
      mcnt = 0;
      idle(3);
      #2 rclk = 1'b0;
      idle(3);
   endtask

   task automatic sim_pulse(input logic b);
      @(posedge clk);
      #2 dio = b;
      idle(2);
      #2 sclk = 1'b1;
      rclk = 1'b1;
      exp_q.push_back('{d: msh, e: mcnt != 16});
      msh = {msh[14:0], b};
      mcnt = 1;
      idle(3);
      #2 sclk = 1'b0;
      rclk = 1'b0;
      idle(3);
   endtask

   task automatic latch(input logic [15:0] w, input int n);
      send_word(w, n);
      pulse_rclk();
      idle(8);
   endtask

   initial begin
      int u;
      logic [7:0] s, sl;
      idle(3);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("reset_dat", 64'(dat), 64'd0);
      chk("reset_vld", 64'(vld), 64'd0);
      chk("reset_frame", frame, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("reset_num", 64'(num), 64'hFFFF_FFFF);
      chk("reset_num_ok", 64'(num_ok), 64'd0);

      latch(16'hC001, 16);
      chk("c001_dat", 64'(last_dat), 64'hC001);
      chk("c001_err", 64'(last_err), 64'd0);
      chk("c001_frame0", 64'(frame[7:0]), 64'hC0);
      chk("c001_num0", 64'(num[3:0]), 64'd0);
      chk("c001_ok0", 64'(num_ok[0]), 64'd1);
      chk("c001_upd", 64'(n_upd), 64'd1);

      for (int i = 0; i < 8; i++) latch({tbl[i], 8'(1 << i)}, 16);
      chk("all_frame", frame, 64'hF882_9299_B0A4_F9C0);
      chk("all_num", 64'(num), 64'h7654_3210);
      chk("all_ok", 64'(num_ok), 64'hFF);

      u = n_upd;
      latch(16'h0ABC, 12);
      chk("short_dat", 64'(last_dat), 64'h0ABC);
      chk("short_err", 64'(last_err), 64'd1);
      chk("short_frame", frame, 64'hF882_9299_B0A4_F9C0);

      latch(16'h8C03, 16);
      chk("multi_dat", 64'(last_dat), 64'h8C03);
      chk("multi_noupd", 64'(n_upd), 64'(u));
      latch(16'h8C04, 16);
      chk("bad_frame2", 64'(frame[23:16]), 64'h8C);
      chk("bad_num2", 64'(num[11:8]), 64'hF);
      chk("bad_ok2", 64'(num_ok[2]), 64'd0);

      send_word(16'h9902, 16);
      sim_pulse(1'b1);
      idle(8);
      chk("coinc_dat", 64'(last_dat), 64'h9902);
      chk("coinc_err", 64'(last_err), 64'd0);
      latch(16'hB008, 15);
      chk("after_coinc_dat", 64'(last_dat), 64'hB008);
      chk("after_coinc_err", 64'(last_err), 64'd0);
      chk("after_coinc_frame3", 64'(frame[31:24]), 64'hB0);

      send_word(16'hFFFF, 16);
      send_word(16'hFFFF, 16);
      latch(16'hFFFF, 16);
      chk("sat_err", 64'(last_err), 64'd1);

      send_word(16'h00FF, 8);
      @(posedge clk);
      #2 rst = 1'b0;
      msh = '0;
      mcnt = 0;
      idle(2);
      #2 rst = 1'b1;
      latch(16'hA404, 16);
      chk("rst_err", 64'(last_err), 64'd0);
      chk("rst_frame", frame, 64'hFFFF_FFFF_FFA4_FFFF);
      chk("rst_num", 64'(num), 64'hFFFF_F2FF);
      chk("rst_ok", 64'(num_ok), 64'h04);

      for (int k = 0; k < 40; k++) begin
         s = $urandom_range(0, 9) < 7 ? tbl[$urandom_range(0, 9)] : 8'($urandom);
         u = $urandom_range(0, 5);
         sl = u == 0 ? 8'h00 : u == 1 ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
         latch({s, sl}, $urandom_range(0, 7) == 0 ? $urandom_range(1, 20) : 16);
      end

      idle(20);
      chk("latches_outstanding", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
